// File: rtl/posn_pulse_gen.sv
// Position-to-pulse generator: walks an internal position towards a signed
// target, emitting one step pulse (with direction) per move for a downstream counter.
module posn_pulse_gen (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic signed [31:0] posn_i,
  input  logic signed [31:0] start,
  input  logic               start_wstb,
  input  logic        [31:0] period,
  input  logic               period_wstb,
  output logic               pulse_o,
  output logic               dir_o,
  output logic signed [31:0] posn_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [31:0] MIN_PERIOD = 32'd2;

  state_t             state, state_next;
  logic        [31:0] period_q;
  logic        [31:0] period_eff;
  logic        [31:0] gap_cnt, gap_next;
  logic               armed;
  logic               dir_next;
  logic signed [31:0] posn_next;
  logic               at_target;
  logic               step_dir;
  logic               gap_done;

  // A fresh period write applies to the GAP decision in the same cycle it arrives.
  always_comb begin
    if (period_wstb) period_eff = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    else             period_eff = period_q;
  end

  assign at_target = (posn_i == posn_o);
  assign step_dir  = (posn_i < posn_o);  // both operands signed: no wrap shortcut
  assign gap_done  = (gap_cnt >= period_eff - 32'd1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_next = state;
    dir_next   = dir_o;
    posn_next  = posn_o;
    gap_next   = gap_cnt;

    unique case (state)
      IDLE: begin
        if (enable_i && armed && !at_target) begin
          state_next = SETUP;
          dir_next   = step_dir;
        end
      end
      SETUP: state_next = PULSE;
      PULSE: begin
        posn_next  = dir_o ? posn_o - 32'sd1 : posn_o + 32'sd1;
        state_next = GAP;
        gap_next   = 32'd1;
      end
      GAP: begin
        if (gap_done) begin
          gap_next = 32'd0;
          if (at_target) begin
            state_next = IDLE;
          end else if (step_dir == dir_o) begin
            state_next = PULSE;
          end else begin
            state_next = SETUP;
            dir_next   = step_dir;
          end
        end else begin
          gap_next = gap_cnt + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Disable freezes position/direction but lets an in-flight PULSE land its step.
    if (!enable_i) begin
      state_next = IDLE;
      dir_next   = dir_o;
      gap_next   = 32'd0;
    end

    if (start_wstb) begin
      state_next = IDLE;
      posn_next  = start;
      dir_next   = dir_o;
      gap_next   = 32'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: only control/state registers exist here, so all of them take the async reset.
    if (reset_i) begin
      state    <= IDLE;
      period_q <= MIN_PERIOD;
      gap_cnt  <= 32'd0;
      armed    <= 1'b0;
      pulse_o  <= 1'b0;
      dir_o    <= 1'b0;
      posn_o   <= 32'sd0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_next;
      period_q <= period_eff;
      gap_cnt  <= gap_next;
      armed    <= 1'b1;
      pulse_o  <= (state_next == PULSE);
      dir_o    <= dir_next;
      posn_o   <= posn_next;
      busy_o   <= (state_next != IDLE);
    end
  end

endmodule
